fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. Owns the PC, issues one-outstanding requests to instruction memory over a req/valid handshake, and presents {pc, instruction, valid} to decode. Consumes the load-use `stall` from the hazard unit, which freezes PC and IF/ID. Consumes the branch-resolution redirect from EX, which flushes IF/ID and retargets the PC.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_skid_buf.sv | 43 ++++
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    FETCH = ST_FETCH,
    DRAIN = ST_DRAIN,
    HOLD  = ST_HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {pc, inst} holding buffer for a fetch response that lands during a stall.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o
);

  logic            full_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;

  // Clear wins over load so a flush can never leave a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      pc_q   <= 32'h0000_0000;
      inst_q <= NOP_INST;
    end else begin
      if (clear_i) begin
        full_q <= 1'b0;
      end else if (load_i) begin
        full_q <= 1'b1;
      end
      if (load_i) begin
        pc_q   <= pc_i;
        inst_q <= inst_i;
      end
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register. Optional perf counters via FETCH_PERF_CNT_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
  output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flushes
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  if_id_t          ifid_q, ifid_d;

  logic            buf_load, buf_clear, buf_full;
  logic [XLEN-1:0] buf_pc, buf_inst;
  logic [XLEN-1:0] tgt_al, pc_inc;
  if_id_t          bubble;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc_i    (pc_q),
    .inst_i  (imem_rdata),
    .full_o  (buf_full),
    .pc_o    (buf_pc),
    .inst_o  (buf_inst)
  );

  // Next-state logic; priority is redirect, then stall, then normal advance.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    tgt_al    = align_word(branch_target);
    pc_inc    = pc_q + 32'd4;
    bubble    = '{pc: pc_q, inst: NOP_INST, valid: 1'b0};

    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d   = tgt_al;
          ifid_d = bubble;
          if (imem_valid) begin
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_valid) begin
          if (stall) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            ifid_d = '{pc: pc_q, inst: imem_rdata, valid: 1'b1};
            pc_d   = pc_inc;
          end
        end else if (!stall) begin
          ifid_d = bubble;
        end else begin
          ifid_d = ifid_q;
        end
      end

      DRAIN: begin
        if (branch_taken) begin
          pc_d = tgt_al;
        end else begin
          pc_d = pc_q;
        end
        if (imem_valid) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
        if (branch_taken || !stall) begin
          ifid_d = bubble;
        end else begin
          ifid_d = ifid_q;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          buf_clear = 1'b1;
          pc_d      = tgt_al;
          ifid_d    = bubble;
          state_d   = FETCH;
        end else if (!stall) begin
          buf_clear = 1'b1;
          ifid_d    = '{pc: buf_pc, inst: buf_inst, valid: buf_full};
          pc_d      = pc_inc;
          state_d   = FETCH;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d   = FETCH;
        buf_clear = 1'b1;
        ifid_d    = bubble;
      end
    endcase

    // While draining, the old request address must stay on the bus.
    if (state_d == DRAIN) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
    req_d = (state_d != HOLD);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b1;
      ifid_q  <= '{pc: 32'h0000_0000, inst: NOP_INST, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_inst  = ifid_q.inst;
  assign if_id_valid = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Stall cycles spent draining are not counted; both counters wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall && (state_q != DRAIN)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_taken) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences and random traffic vs a reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc, if_id_inst;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
  logic [31:0] pstall, pflush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  // ---------------- memory model ----------------
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_a;
  int          lat_cfg;
  bit          lat_rand;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h00A0_0093;
    return {a[31:2] ^ 30'h2ABC_DEF, 2'b11};
  endfunction

  task automatic mem_reset();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    mem_busy   = 1'b0;
    mem_cnt    = 0;
    mem_a      = 32'h0;
  endtask

  task automatic mem_step(input logic pre_req, input logic [31:0] pre_addr, input logic pre_v);
    int lat;
    if (pre_v) begin
      imem_valid = 1'b0;
      mem_busy   = 1'b0;
    end else if (mem_busy) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = memf(mem_a);
      end
    end else if (pre_req) begin
      lat      = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
      mem_busy = 1'b1;
      mem_a    = pre_addr;
      mem_cnt  = lat - 1;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = memf(mem_a);
      end
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  pair_t       held_q[$];     // response captured during a stall
  bit          m_discard;     // a redirected request is still in flight
  logic [31:0] m_pc, m_drain_addr;
  logic        m_v;
  logic [31:0] m_ipc, m_iinst;

  task automatic model_reset();
    held_q.delete();
    m_discard    = 1'b0;
    m_pc         = 32'h0;
    m_drain_addr = 32'h0;
    m_v          = 1'b0;
    m_ipc        = 32'h0;
    m_iinst      = NOP;
`ifdef FETCH_PERF_CNT_EN
    pstall = 32'd0;
    pflush = 32'd0;
`endif
  endtask

  task automatic model_bubble();
    m_v     = 1'b0;
    m_iinst = NOP;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                            input logic v, input logic [31:0] rd);
    logic [31:0] ta;
    ta = t & 32'hFFFF_FFFC;
`ifdef FETCH_PERF_CNT_EN
    if (s && !m_discard) pstall = pstall + 32'd1;
    if (b) pflush = pflush + 32'd1;
`endif
    if (held_q.size() != 0) begin
      if (b) begin
        held_q.delete();
        m_pc = ta;
        model_bubble();
      end else if (!s) begin
        m_v     = 1'b1;
        m_ipc   = held_q[0].pc;
        m_iinst = held_q[0].inst;
        held_q.delete();
        m_pc = m_pc + 32'd4;
      end
    end else if (m_discard) begin
      if (b) m_pc = ta;
      if (v) m_discard = 1'b0;
      if (b || !s) model_bubble();
    end else begin
      if (b) begin
        if (!v) begin
          m_discard    = 1'b1;
          m_drain_addr = m_pc;
        end
        m_pc = ta;
        model_bubble();
      end else if (v) begin
        if (s) begin
          held_q.push_back('{pc: m_pc, inst: rd});
        end else begin
          m_v     = 1'b1;
          m_ipc   = m_pc;
          m_iinst = rd;
          m_pc    = m_pc + 32'd4;
        end
      end else if (!s) begin
        model_bubble();
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    logic        e_req;
    logic [31:0] e_addr;
    e_req  = (held_q.size() == 0);
    e_addr = m_discard ? m_drain_addr : m_pc;
    check("model_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) check("model_addr", imem_addr, e_addr);
    check("model_valid", {31'b0, if_id_valid}, {31'b0, m_v});
    check("model_inst", if_id_inst, m_iinst);
    if (m_v) check("model_pc", if_id_pc, m_ipc);
  endtask

  // One clock: drive inputs, let the edge happen, update models, compare on the falling edge.
  task automatic cycle(input logic s, input logic b, input logic [31:0] t);
    logic        pre_req, pre_v;
    logic [31:0] pre_addr, pre_rd;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    pre_req  = imem_req;
    pre_addr = imem_addr;
    pre_v    = imem_valid;
    pre_rd   = imem_rdata;
    if (mem_busy && pre_req) check("addr_stable", pre_addr, mem_a);
    @(posedge clk);
    #1;
    model_step(s, b, t, pre_v, pre_rd);
    mem_step(pre_req, pre_addr, pre_v);
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   {31'b0, imem_req},    32'h1);
    check({tag, "_addr"},  imem_addr,            32'h0);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_pc"},    if_id_pc,             32'h0);
    check({tag, "_inst"},  if_id_inst,           NOP);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_pstall"}, perf_stall_cycles, 32'h0);
    check({tag, "_pflush"}, perf_flushes,      32'h0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    mem_reset();
    model_reset();
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        e_req;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    lat_cfg = 1;
    lat_rand = 1'b0;
    mem_reset();
    model_reset();
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;

    tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, memf(32'h0)};
    tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, NOP};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, memf(32'h4)};
    tbl[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, memf(32'h4)};
    tbl[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, memf(32'h4)};
    tbl[6] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, memf(32'h4)};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h00A0_0093};
    tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0, NOP};
    tbl[9] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, memf(32'hC)};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].s, tbl[i].b, tbl[i].t);
      check($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].chk_addr) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].e_v});
      check($sformatf("tbl%0d_inst", i), if_id_inst, tbl[i].e_inst);
      if (tbl[i].e_v) check($sformatf("tbl%0d_pc", i), if_id_pc, tbl[i].e_pc);
    end

    // Redirect while a 3-cycle request to 0x20 is pending.
    do_reset();
    lat_cfg = 3;
    cycle(1'b0, 1'b1, 32'h20);
    n = 0;
    while (imem_addr !== 32'h20 && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    check("reach_0x20", imem_addr, 32'h20);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h100);
    check("drain_addr0", imem_addr, 32'h20);
    check("drain_valid0", {31'b0, if_id_valid}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("drain_addr1", imem_addr, 32'h20);
    check("drain_valid1", {31'b0, if_id_valid}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("drain_newaddr", imem_addr, 32'h100);
    check("drain_discard", {31'b0, if_id_valid}, 32'h0);
    n = 0;
    while (if_id_valid !== 1'b1 && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    check("redirect_pc", if_id_pc, 32'h100);
    check("redirect_inst", if_id_inst, memf(32'h100));

    // Redirect and stall together while holding a response; unaligned target.
    do_reset();
    lat_cfg = 1;
    n = 0;
    while (imem_req !== 1'b0 && n < 20) begin
      cycle(1'b1, 1'b0, 32'h0);
      n++;
    end
    check("enter_hold", {31'b0, imem_req}, 32'h0);
    cycle(1'b1, 1'b1, 32'h103);
    check("hold_flush_valid", {31'b0, if_id_valid}, 32'h0);
    check("hold_flush_req", {31'b0, imem_req}, 32'h1);
    check("hold_flush_addr", imem_addr, 32'h100);
    n = 0;
    while (if_id_valid !== 1'b1 && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    check("hold_flush_pc", if_id_pc, 32'h100);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    n = 0;
    while (!(if_id_valid === 1'b1 && if_id_pc === 32'hFFFF_FFFC) && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_inst", if_id_inst, memf(32'hFFFF_FFFC));
    check("wrap_next_addr", imem_addr, 32'h0);

    // Random traffic against the reference model.
    lat_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic        rs, rb;
      logic [31:0] rt;
      rs = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 9) == 0);
      rt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFF);
      cycle(rs, rb, rt);
    end
    lat_rand = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    check("perf_stall_cycles", perf_stall_cycles, pstall);
    check("perf_flushes", perf_flushes, pflush);
`endif

    // Asynchronous reset in the middle of an outstanding request.
    lat_cfg = 3;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    stall = 1'b0;
    branch_taken = 1'b0;
    mem_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
